// File: rtl/reg8_arbiter_if.sv
// Requester-side handshake bundle for reg8_arbiter: two req/ack channels plus shared read data and busy.
interface reg8_arbiter_if #(
    parameter int ADDR_W = 2
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [7:0]        wdata_a;
    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [7:0]        wdata_b;
    logic              ack_a;
    logic              ack_b;
    logic [7:0]        rdata;
    logic              busy;

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  ack_a, ack_b, rdata, busy
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output ack_a, ack_b, rdata, busy
    );
endinterface

// File: rtl/reg8_arbiter.sv
// Round-robin arbiter sharing a bank of NREG 8-bit enable-load registers between requesters A and B.
module reg8_arbiter #(
    parameter int NREG   = 4,
    parameter int ADDR_W = 2
) (
    input  logic              Clk,
    input  logic              Res,
    reg8_arbiter_if.slave     bus,
    output logic [NREG-1:0]   reg_en,
    output logic [7:0]        reg_din,
    input  logic [8*NREG-1:0] reg_q
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              grant;
    logic              grant_b;
    logic              win_b;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [7:0]        lat_wdata;
    logic              last_b;
    logic [7:0]        rdata_q;

    always_ff @(posedge Clk or negedge Res) begin
        if (!Res) begin
            state     <= IDLE;
            win_b     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 8'h00;
            last_b    <= 1'b1;
            rdata_q   <= 8'h00;
        end else begin
            state <= state_nx;
            if (grant) begin
                win_b     <= grant_b;
                lat_we    <= grant_b ? bus.we_b    : bus.we_a;
                lat_addr  <= grant_b ? bus.addr_b  : bus.addr_a;
                lat_wdata <= grant_b ? bus.wdata_b : bus.wdata_a;
                last_b    <= grant_b;
            end
            // Read data is taken from the bank at the end of ACCESS and held until the next read.
            if (state == ACCESS && !lat_we) begin
                rdata_q <= reg_q[{lat_addr, 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        grant_b   = 1'b0;
        reg_en    = '0;
        reg_din   = lat_wdata;
        bus.ack_a = 1'b0;
        bus.ack_b = 1'b0;
        bus.busy  = (state != IDLE);
        bus.rdata = rdata_q;
        case (state)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (bus.req_a || bus.req_b) begin
                    grant    = 1'b1;
                    grant_b  = bus.req_b && (!bus.req_a || !last_b);
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_we) begin
                    reg_en[lat_addr] = 1'b1;
                end
                state_nx = ACK;
            end
            ACK: begin
                bus.ack_a = !win_b;
                bus.ack_b = win_b;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg8_arbiter.sv
// Testbench for reg8_arbiter: behavioural register bank plus a queue-free reference model of the bank contents.
module tb_reg8_arbiter;

    logic        Clk = 1'b0;
    logic        Res = 1'b0;
    logic [3:0]  reg_en;
    logic [7:0]  reg_din;
    logic [31:0] reg_q;
    logic [7:0]  bank [4] = '{default: 8'h00};

    logic [7:0]  exp_mem [4] = '{default: 8'h00};
    logic [7:0]  exp_rdata = 8'h00;
    bit          model_last_b = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg8_arbiter_if #(.ADDR_W(2)) bus ();

    reg8_arbiter #(.NREG(4), .ADDR_W(2)) dut (
        .Clk    (Clk),
        .Res    (Res),
        .bus    (bus),
        .reg_en (reg_en),
        .reg_din(reg_din),
        .reg_q  (reg_q)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reg_en[i]) bank[i] <= reg_din;
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < 4; i++) reg_q[i*8 +: 8] = bank[i];
    end

    task automatic clear_reqs();
        bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = 2'd0; bus.wdata_a = 8'h00;
        bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = 2'd0; bus.wdata_b = 8'h00;
    endtask

    task automatic set_req(input bit side_b, input bit we, input logic [1:0] addr, input logic [7:0] data);
        if (side_b) begin
            bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = data;
        end else begin
            bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = data;
        end
    endtask

    task automatic test_reset();
        Res = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            bus.req_a = 1'($urandom); bus.we_a = 1'($urandom);
            bus.addr_a = 2'($urandom); bus.wdata_a = 8'($urandom);
            bus.req_b = 1'($urandom); bus.we_b = 1'($urandom);
            bus.addr_b = 2'($urandom); bus.wdata_b = 8'($urandom);
        end
        @(negedge Clk);
        total_cnt++; if (bus.ack_a !== 1'b0) $display("[TB] FAIL reset_ack_a: got %b want 0", bus.ack_a); else pass_cnt++;
        total_cnt++; if (bus.ack_b !== 1'b0) $display("[TB] FAIL reset_ack_b: got %b want 0", bus.ack_b); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (reg_en !== 4'b0000) $display("[TB] FAIL reset_reg_en: got %b want 0000", reg_en); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h want 00", bus.rdata); else pass_cnt++;
        clear_reqs();
    endtask

    // Both requesters held across reset release: A must win the first tie.
    task automatic test_tie_from_reset();
        int ta = -1;
        int tb = -1;
        set_req(1'b0, 1'b1, 2'd0, 8'h11);
        set_req(1'b1, 1'b1, 2'd1, 8'h22);
        @(negedge Clk);
        Res = 1'b1;
        for (int c = 1; c <= 12 && (ta < 0 || tb < 0); c++) begin
            @(negedge Clk);
            if (bus.ack_a && ta < 0) begin ta = c; bus.req_a = 1'b0; end
            if (bus.ack_b && tb < 0) begin tb = c; bus.req_b = 1'b0; end
        end
        total_cnt++; if (ta !== 2) $display("[TB] FAIL tie_ack_a_cycle: got %0d want 2", ta); else pass_cnt++;
        total_cnt++; if (tb - ta !== 3) $display("[TB] FAIL tie_ack_spacing: got %0d want 3", tb - ta); else pass_cnt++;
        exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; model_last_b = 1'b1;
        total_cnt++; if (bank[0] !== exp_mem[0]) $display("[TB] FAIL tie_reg0: got %h want %h", bank[0], exp_mem[0]); else pass_cnt++;
        total_cnt++; if (bank[1] !== exp_mem[1]) $display("[TB] FAIL tie_reg1: got %h want %h", bank[1], exp_mem[1]); else pass_cnt++;
        clear_reqs();
    endtask

    task automatic test_write();
        int ta = -1;
        int en_cnt = 0;
        logic [3:0] en_val = 4'b0000;
        logic [7:0] din = 8'h00;
        bit ab = 1'b0;
        @(negedge Clk);
        set_req(1'b0, 1'b1, 2'd2, 8'hA5);
        for (int c = 1; c <= 8 && ta < 0; c++) begin
            @(negedge Clk);
            if (reg_en !== 4'b0000) begin en_cnt++; en_val = reg_en; din = reg_din; end
            if (bus.ack_b) ab = 1'b1;
            if (bus.ack_a) begin ta = c; bus.req_a = 1'b0; end
        end
        exp_mem[2] = 8'hA5; model_last_b = 1'b0;
        total_cnt++; if (ta !== 2) $display("[TB] FAIL write_ack_cycle: got %0d want 2", ta); else pass_cnt++;
        total_cnt++; if (en_cnt !== 1) $display("[TB] FAIL write_en_cycles: got %0d want 1", en_cnt); else pass_cnt++;
        total_cnt++; if (en_val !== 4'b0100) $display("[TB] FAIL write_en_value: got %b want 0100", en_val); else pass_cnt++;
        total_cnt++; if (din !== 8'hA5) $display("[TB] FAIL write_din: got %h want a5", din); else pass_cnt++;
        total_cnt++; if (ab !== 1'b0) $display("[TB] FAIL write_ack_b: got %b want 0", ab); else pass_cnt++;
        total_cnt++; if (bank[2] !== exp_mem[2]) $display("[TB] FAIL write_reg2: got %h want %h", bank[2], exp_mem[2]); else pass_cnt++;
        clear_reqs();
    endtask

    task automatic test_read();
        int tb = -1;
        bit en_any = 1'b0;
        bit aa = 1'b0;
        logic [7:0] rd = 8'h00;
        @(negedge Clk);
        set_req(1'b1, 1'b0, 2'd2, 8'h5A);
        for (int c = 1; c <= 8 && tb < 0; c++) begin
            @(negedge Clk);
            if (reg_en !== 4'b0000) en_any = 1'b1;
            if (bus.ack_a) aa = 1'b1;
            if (bus.ack_b) begin tb = c; rd = bus.rdata; bus.req_b = 1'b0; end
        end
        exp_rdata = exp_mem[2]; model_last_b = 1'b1;
        total_cnt++; if (tb !== 2) $display("[TB] FAIL read_ack_cycle: got %0d want 2", tb); else pass_cnt++;
        total_cnt++; if (rd !== exp_rdata) $display("[TB] FAIL read_rdata: got %h want %h", rd, exp_rdata); else pass_cnt++;
        total_cnt++; if (aa !== 1'b0) $display("[TB] FAIL read_ack_a: got %b want 0", aa); else pass_cnt++;
        repeat (3) begin
            @(negedge Clk);
            if (reg_en !== 4'b0000) en_any = 1'b1;
        end
        total_cnt++; if (en_any !== 1'b0) $display("[TB] FAIL read_reg_en: got %b want 0", en_any); else pass_cnt++;
        total_cnt++; if (bus.rdata !== exp_rdata) $display("[TB] FAIL read_hold: got %h want %h", bus.rdata, exp_rdata); else pass_cnt++;
        clear_reqs();
    endtask

    task automatic test_wdata_change();
        int ta = -1;
        @(negedge Clk);
        set_req(1'b0, 1'b1, 2'd3, 8'h3C);
        for (int c = 1; c <= 8 && ta < 0; c++) begin
            @(negedge Clk);
            if (c == 1) bus.wdata_a = 8'hFF;
            if (bus.ack_a) begin ta = c; bus.req_a = 1'b0; end
        end
        exp_mem[3] = 8'h3C; model_last_b = 1'b0;
        total_cnt++; if (ta !== 2) $display("[TB] FAIL late_change_ack_cycle: got %0d want 2", ta); else pass_cnt++;
        total_cnt++; if (bank[3] !== exp_mem[3]) $display("[TB] FAIL late_change_reg3: got %h want %h", bank[3], exp_mem[3]); else pass_cnt++;
        clear_reqs();
    endtask

    task automatic test_reset_in_access();
        int acks = 0;
        @(negedge Clk);
        set_req(1'b0, 1'b1, 2'd1, 8'h77);
        @(negedge Clk);
        total_cnt++; if (reg_en !== 4'b0010) $display("[TB] FAIL abort_en_before: got %b want 0010", reg_en); else pass_cnt++;
        #1 Res = 1'b0;
        #1;
        total_cnt++; if (reg_en !== 4'b0000) $display("[TB] FAIL abort_en_after: got %b want 0000", reg_en); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", bus.busy); else pass_cnt++;
        repeat (3) begin
            @(negedge Clk);
            if (bus.ack_a || bus.ack_b) acks++;
        end
        clear_reqs();
        Res = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (bus.ack_a || bus.ack_b) acks++;
        end
        exp_rdata = 8'h00; model_last_b = 1'b1;
        total_cnt++; if (acks !== 0) $display("[TB] FAIL abort_acks: got %0d want 0", acks); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL abort_idle: got busy %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bank[1] !== exp_mem[1]) $display("[TB] FAIL abort_reg1: got %h want %h", bank[1], exp_mem[1]); else pass_cnt++;
        total_cnt++; if (bus.rdata !== exp_rdata) $display("[TB] FAIL abort_rdata: got %h want %h", bus.rdata, exp_rdata); else pass_cnt++;
    endtask

    // Random rounds: each round raises one or both requests; the model decides who must be served next.
    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            bit pa, pb, got_b, exp_b;
            bit we [2];
            logic [1:0] ad [2];
            logic [7:0] dt [2];
            int budget = 20;
            int pick = $urandom_range(1, 3);
            pa = pick[0]; pb = pick[1];
            for (int s = 0; s < 2; s++) begin
                we[s] = 1'($urandom); ad[s] = 2'($urandom); dt[s] = 8'($urandom);
            end
            @(negedge Clk);
            if (pa) set_req(1'b0, we[0], ad[0], dt[0]);
            if (pb) set_req(1'b1, we[1], ad[1], dt[1]);
            while ((pa || pb) && budget > 0) begin
                @(negedge Clk);
                budget--;
                if (bus.ack_a || bus.ack_b) begin
                    got_b = bus.ack_b;
                    exp_b = (pa && pb) ? !model_last_b : pb;
                    total_cnt++; if (got_b !== exp_b) $display("[TB] FAIL rand_winner r%0d: got %s want %s", r, got_b ? "B" : "A", exp_b ? "B" : "A"); else pass_cnt++;
                    if (we[got_b]) exp_mem[ad[got_b]] = dt[got_b];
                    else begin
                        exp_rdata = exp_mem[ad[got_b]];
                        total_cnt++; if (bus.rdata !== exp_rdata) $display("[TB] FAIL rand_rdata r%0d: got %h want %h", r, bus.rdata, exp_rdata); else pass_cnt++;
                    end
                    model_last_b = got_b;
                    if (got_b) begin pb = 1'b0; bus.req_b = 1'b0; end
                    else begin pa = 1'b0; bus.req_a = 1'b0; end
                end
            end
            if (pa || pb) begin
                total_cnt++;
                $display("[TB] FAIL rand_timeout r%0d: got no ack want ack within 20 cycles", r);
                clear_reqs();
            end
        end
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (bank[i] !== exp_mem[i]) $display("[TB] FAIL rand_reg%0d: got %h want %h", i, bank[i], exp_mem[i]); else pass_cnt++;
        end
        clear_reqs();
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_tie_from_reset();
        test_write();
        test_read();
        test_wdata_change();
        test_reset_in_access();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg8_arbiter.md
# reg8_arbiter

Controller that shares a bank of NREG 8-bit enable-load registers between two requesters (A and B). It accepts read/write requests on a req/ack handshake, arbitrates round-robin when both are pending, and drives the bank's per-register load enables and common data input. It also returns read data sampled from the bank outputs. It sits between the bank of 8-bit registers and the two datapath agents that use them.

## Interface
- NREG, 4, number of registers in the bank; must equal 2**ADDR_W.
- ADDR_W, 2, register address width.

- Clk  in  1  clock; all state changes on rising edge.
- Res  in  1  asynchronous, active-low reset.
- req_a  in  1  requester A request; held high and stable with we_a/addr_a/wdata_a until ack_a.
- we_a  in  1  1 = write, 0 = read.
- addr_a  in  ADDR_W  target register.
- wdata_a  in  8  write data.
- req_b, we_b, addr_b, wdata_b  in  1/1/ADDR_W/8  same meaning for requester B.
- ack_a  out  1  one-cycle completion pulse for A.
- ack_b  out  1  one-cycle completion pulse for B.
- rdata  out  8  read result; valid from the ack cycle of a read and held until the next read completes.
- busy  out  1  high whenever state is not IDLE.
- reg_en  out  NREG  one-hot load enables to the bank (bit i = register i); 1 = load reg_din on next Clk edge.
- reg_din  out  8  common data input to all bank registers.
- reg_q  in  8*NREG  concatenated bank outputs; register i occupies bits [8i+7:8i].

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester other than the last one served. The pointer resets to "B last served", so A wins the first tie.
  - On grant, latch the winner id, we, addr and wdata into internal registers, update the pointer, and go to ACCESS.
- ACCESS, exactly one cycle:
  - Write: reg_en[latched addr] = 1 and all other bits 0; reg_din = latched wdata.
  - Read: reg_en = 0; at the end of the cycle, rdata captures reg_q slice [latched addr].
  - Always go to ACK.
- ACK, exactly one cycle:
  - ack of the latched winner = 1; the other ack = 0.
  - Always go to IDLE.
- reg_en is zero in IDLE and ACK.
- reg_din equals the latched wdata in all states; the bank ignores it when reg_en = 0.
- Requester inputs are used only at the grant edge. Changes after grant do not affect the transaction.
- If a req is still high in the IDLE cycle after its ack, it is treated as a new request.
- A requester that drops req before grant is simply not served; nothing is recorded.
- Reset values, applied immediately on Res low: state IDLE, ack_a = ack_b = 0, busy = 0, reg_en = 0, rdata = 0x00, latched fields = 0, pointer = B last served.
- Reset during ACCESS: reg_en falls immediately, so no write occurs unless a Clk edge happened first. No ack is issued; the transaction is lost.

## Timing
- Request high with the FSM in IDLE is sampled at edge E0.
  - Cycle after E0: ACCESS; reg_en is active during this cycle.
  - Edge E1: the write lands in the bank, or rdata is captured.
  - Cycle after E1: ACK; ack is high and rdata is valid.
  - Edge E2: back to IDLE.
- Latency from sampling edge to ack is 2 cycles. Throughput is one transaction per 3 cycles.
- With both requesters continuously asserting, grants alternate A, B, A, B, and each requester waits at most one transaction.
- Write then read of the same address returns the new value; the write commits at E1, before any later ACCESS.
- busy is high in the ACCESS and ACK cycles.

## Test plan
- Reset: hold Res low with random inputs -> ack_a = ack_b = 0, busy = 0, reg_en = 0, rdata = 0x00. After release, the first tie is granted to A.
- A writes 0xA5 to addr 2 -> reg_en = 4'b0100 for exactly one cycle, reg_din = 0xA5, register 2 = 0xA5 after E1, ack_a pulses in the following cycle, ack_b stays 0.
- After the previous scenario, B reads addr 2 -> rdata = 0xA5 in the ack_b cycle and holds 0xA5 through idle cycles; reg_en stays 0 throughout.
- A (write 0x11 to addr 0) and B (write 0x22 to addr 1) held together from reset -> A serviced first, then B. Reg0 = 0x11 and reg1 = 0x22. The ack_a and ack_b pulses are 3 cycles apart.
- Change wdata_a to 0xFF in the ACCESS cycle of a 0x3C write to addr 3 -> register 3 = 0x3C.
- Drop Res during the ACCESS cycle of a write of 0x77 to addr 1 -> reg_en goes to 0 at once, no ack. Register 1 keeps its prior value, and the FSM returns to IDLE after release.
